// File: rtl/latch_write_arbiter_pkg.sv
// Shared types and defaults for the latch write arbiter: FSM encoding,
// default parameter values and the round-robin index helper.
package latch_write_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WRITE = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  localparam int unsigned DefWidth        = 8;
  localparam int unsigned DefNreq         = 4;
  localparam int unsigned DefEnableCycles = 2;

  // Index reached by stepping 'off' places past 'base' in a ring of n.
  function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set req bit searching from last+1
// upward (mod NREQ); 'any' flags that a winner exists.
module rr_priority_pick
  import latch_write_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] win_idx,
  output logic                    any
);

  localparam int unsigned IdxW = $clog2(NREQ);

  always_comb begin
    int unsigned k;
    k       = 0;
    win_idx = '0;
    any     = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      k = wrap_add(32'(last), i, NREQ);
      if (!any && req[k[IdxW-1:0]]) begin
        any     = 1'b1;
        win_idx = k[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Round-robin owner of a shared D-latch bank; sequences each write as
// setup, ENABLE_CYCLES-long enable pulse, then hold, all outputs registered.
module latch_write_arbiter
  import latch_write_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH         = DefWidth,
  parameter int unsigned NREQ          = DefNreq,
  parameter int unsigned ENABLE_CYCLES = DefEnableCycles
) (
  input  logic                  Clk,
  input  logic                  reset_b,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      latch_D,
  output logic                  latch_enable,
  output logic                  busy
);

  localparam int unsigned IdxW = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(ENABLE_CYCLES + 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] last_q;
  logic [IdxW-1:0] win_idx;
  logic            any;

  rr_priority_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req    (req),
    .last   (last_q),
    .win_idx(win_idx),
    .any    (any)
  );

  always_ff @(posedge Clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_q       <= IdxW'(NREQ - 1);
      grant        <= '0;
      done         <= '0;
      latch_D      <= '0;
      latch_enable <= 1'b0;
      busy         <= 1'b0;
    end else begin
      done <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (any) begin
            grant   <= NREQ'(1) << win_idx;
            latch_D <= data_in[win_idx*WIDTH +: WIDTH];
            last_q  <= win_idx;
            busy    <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          latch_enable <= 1'b1;
          cnt_q        <= CntW'(1);
          state_q      <= S_WRITE;
        end
        S_WRITE: begin
          if (cnt_q == CntW'(ENABLE_CYCLES)) begin
            latch_enable <= 1'b0;
            done         <= grant;
            state_q      <= S_HOLD;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        S_HOLD: begin
          grant   <= '0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Scoreboard bench for latch_write_arbiter: stimulus pushes expected
// (owner, data) pairs; a monitor pops them on each done pulse.
module tb_latch_write_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int EN    = 2;

  logic                  Clk = 1'b0;
  logic                  reset_b = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] data_in = '0;
  logic [NREQ-1:0]       grant, done;
  logic [WIDTH-1:0]      latch_D;
  logic                  latch_enable, busy;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   age = 0;
  logic [WIDTH-1:0] latch_q;

  latch_write_arbiter #(
    .WIDTH(WIDTH),
    .NREQ(NREQ),
    .ENABLE_CYCLES(EN)
  ) dut (
    .Clk         (Clk),
    .reset_b     (reset_b),
    .req         (req),
    .data_in     (data_in),
    .grant       (grant),
    .done        (done),
    .latch_D     (latch_D),
    .latch_enable(latch_enable),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  // Behavioural latch bank fed by the arbiter.
  always_latch begin
    if (latch_enable) latch_q <= latch_D;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_write(input int idx, input logic [7:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge Clk);
      if (|done) seen = 1'b1;
    end
    check({name, "_timeout"}, 32'(seen), 32'd1);
  endtask

  // Monitor: timing invariants every cycle, scoreboard pop on each done.
  always @(negedge Clk) begin
    if (!reset_b) begin
      age = 0;
    end else begin
      age = (grant != '0) ? age + 1 : 0;
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      check("busy_eq_grant", 32'(busy), 32'(|grant));
      check("enable_window", 32'(latch_enable), 32'(age >= 2 && age <= EN + 1));
      check("done_window", 32'(|done), 32'(age == EN + 2));
      if (|done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_owner", 32'(done), 32'(4'b0001 << e.idx));
          check("latch_D_hold", 32'(latch_D), 32'(e.data));
          check("latch_q", 32'(latch_q), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    longint t_prev;

    // Reset values
    #12;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_latch_D", 32'(latch_D), 32'd0);
    check("rst_enable", 32'(latch_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_b = 1'b1;

    // Single write from requester 0
    @(posedge Clk); #1;
    data_in[0*WIDTH +: WIDTH] = 8'hA5;
    req = 4'b0001;
    expect_write(0, 8'hA5);
    @(posedge Clk);
    @(negedge Clk);
    check("t2_grant", 32'(grant), 32'h1);
    check("t2_latch_D", 32'(latch_D), 32'hA5);
    check("t2_enable_setup", 32'(latch_enable), 32'd0);
    wait_done("t2");
    @(posedge Clk); #1;
    req = '0;

    // Data captured at grant; later changes ignored
    data_in[1*WIDTH +: WIDTH] = 8'h3C;
    req = 4'b0010;
    expect_write(1, 8'h3C);
    @(posedge Clk); #1;
    data_in[1*WIDTH +: WIDTH] = 8'hFF;
    check("t4_grant", 32'(grant), 32'h2);
    wait_done("t4");
    @(posedge Clk); #1;
    req = '0;

    // req[2] dropped during WRITE: write still completes, no re-grant
    data_in[2*WIDTH +: WIDTH] = 8'h5A;
    req = 4'b0100;
    expect_write(2, 8'h5A);
    @(posedge Clk);
    @(posedge Clk);
    @(posedge Clk); #1;
    req = '0;
    wait_done("t5");
    repeat (4) @(negedge Clk);
    check("t5_no_regrant", 32'(grant), 32'd0);

    // Async reset mid-WRITE
    @(posedge Clk); #1;
    data_in[0*WIDTH +: WIDTH] = 8'h77;
    req = 4'b0001;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    check("t1_enable_before", 32'(latch_enable), 32'd1);
    #1 reset_b = 1'b0;
    #1;
    check("t1_enable_async", 32'(latch_enable), 32'd0);
    check("t1_grant_async", 32'(grant), 32'd0);
    req = '0;
    #1 reset_b = 1'b1;
    @(negedge Clk);
    check("t1_grant_after", 32'(grant), 32'd0);
    check("t1_done_after", 32'(done), 32'd0);
    check("t1_latch_D_after", 32'(latch_D), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);

    // All requesting, held: order 0,1,2,3,0 with 5-cycle spacing
    @(posedge Clk); #1;
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    expect_write(0, 8'h11);
    expect_write(1, 8'h22);
    expect_write(2, 8'h33);
    expect_write(3, 8'h44);
    expect_write(0, 8'h11);
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_done("t3");
      if (k > 0) check("t3_spacing", 32'($time - t_prev), 32'd50);
      t_prev = $time;
    end
    @(posedge Clk); #1;
    req = '0;
    repeat (4) @(negedge Clk);
    check("t3_idle", 32'(grant), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
